// File: rtl/led_blink_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_blink_pkg : shared state encoding and default widths for the   |
// |                 LED blink sequencer                                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package led_blink_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int PWM_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } led_state_e;

endpackage
`default_nettype wire

// File: rtl/led_pwm_dimmer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pwm_dimmer : free-running PWM counter with duty compare         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module led_pwm_dimmer
  import led_blink_pkg::*;
#(
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  output logic             dim_on
);

  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // duty==0 never lights; all-ones leaves exactly one dark slot per window
  assign dim_on = (pwm_cnt_q < duty);

endmodule
`default_nettype wire

// File: rtl/led_blink_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_blink_sequencer : tick-driven programmable ON/OFF LED pattern   |
// |   with shadowed config; define LED_DIM_EN for PWM dimming (DUTY).   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module led_blink_sequencer
  import led_blink_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic             TICK,
  input  logic             ENABLE,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [CNT_W-1:0] CFG_ON,
  input  logic [CNT_W-1:0] CFG_OFF,
  output logic             LED,
  output logic             PHASE_DONE
`ifdef LED_DIM_EN
  ,
  input  logic [PWM_W-1:0] DUTY
`endif
);

  led_state_e       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] on_len_q,     on_len_d;
  logic [CNT_W-1:0] off_len_q,    off_len_d;
  logic [CNT_W-1:0] sh_on_q,      sh_on_d;
  logic [CNT_W-1:0] sh_off_q,     sh_off_d;
  logic             pending_q,    pending_d;
  logic             phase_done_q, phase_done_d;

  logic             accept;
  logic             boundary;
  logic [CNT_W-1:0] new_on;
  logic [CNT_W-1:0] new_off;
  logic             dim_on;

  assign accept  = CFG_VALID & ~pending_q;
  assign new_on  = pending_q ? sh_on_q  : on_len_q;
  assign new_off = pending_q ? sh_off_q : off_len_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    on_len_d     = on_len_q;
    off_len_d    = off_len_q;
    sh_on_d      = sh_on_q;
    sh_off_d     = sh_off_q;
    pending_d    = pending_q;
    phase_done_d = 1'b0;
    boundary     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // A config shadowed just before ENABLE dropped would otherwise never
        // reach a boundary, so IDLE promotes it.
        if (pending_q) begin
          on_len_d  = sh_on_q;
          off_len_d = sh_off_q;
          pending_d = 1'b0;
        end else if (accept) begin
          on_len_d  = CFG_ON;
          off_len_d = CFG_OFF;
        end
        if (ENABLE && ((on_len_q | off_len_q) != '0)) begin
          state_d = (on_len_q != '0) ? ST_ON : ST_OFF;
        end
      end
      ST_ON: begin
        if (ENABLE && TICK) begin
          if (cnt_q == on_len_q - CNT_W'(1)) begin
            cnt_d = '0;
            if (off_len_q == '0) begin
              boundary = 1'b1;
            end else begin
              state_d = ST_OFF;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OFF: begin
        if (ENABLE && TICK) begin
          if (cnt_q == off_len_q - CNT_W'(1)) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (boundary) begin
      phase_done_d = 1'b1;
      on_len_d     = new_on;
      off_len_d    = new_off;
      pending_d    = 1'b0;
      if ((new_on | new_off) == '0) begin
        state_d = ST_IDLE;
      end else begin
        state_d = (new_on != '0) ? ST_ON : ST_OFF;
      end
    end

    // Accepted while running: held in the shadow until the next boundary,
    // even when this very edge is itself a boundary.
    if (accept && (state_q != ST_IDLE)) begin
      sh_on_d   = CFG_ON;
      sh_off_d  = CFG_OFF;
      pending_d = 1'b1;
    end

    if (!ENABLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      on_len_q     <= '0;
      off_len_q    <= '0;
      sh_on_q      <= '0;
      sh_off_q     <= '0;
      pending_q    <= 1'b0;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      on_len_q     <= on_len_d;
      off_len_q    <= off_len_d;
      sh_on_q      <= sh_on_d;
      sh_off_q     <= sh_off_d;
      pending_q    <= pending_d;
      phase_done_q <= phase_done_d;
    end
  end

`ifdef LED_DIM_EN
  led_pwm_dimmer #(
    .PWM_W (PWM_W)
  ) u_dimmer (
    .clk    (CLK100MHZ),
    .rst    (RST),
    .duty   (DUTY),
    .dim_on (dim_on)
  );
`else
  // Without the dimmer the ON phase is always full brightness.
  assign dim_on = (PWM_W > 0);
`endif

  assign CFG_READY  = ~pending_q;
  assign PHASE_DONE = phase_done_q;
  assign LED        = (state_q == ST_ON) & dim_on;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_led_blink_sequencer : directed scoreboard bench for the LED      |
// |   blink sequencer (DUTY/dimming test only with LED_DIM_EN)          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_led_blink_sequencer;

  logic       CLK100MHZ = 1'b0;
  logic       RST       = 1'b1;
  logic       TICK      = 1'b0;
  logic       ENABLE    = 1'b0;
  logic       CFG_VALID = 1'b0;
  logic [7:0] CFG_ON    = 8'd0;
  logic [7:0] CFG_OFF   = 8'd0;
  logic       CFG_READY;
  logic       LED;
  logic       PHASE_DONE;
`ifdef LED_DIM_EN
  logic [3:0] DUTY      = 4'd15;
`endif

  led_blink_sequencer #(
    .CNT_W (8),
    .PWM_W (4)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .RST        (RST),
    .TICK       (TICK),
    .ENABLE     (ENABLE),
    .CFG_VALID  (CFG_VALID),
    .CFG_READY  (CFG_READY),
    .CFG_ON     (CFG_ON),
    .CFG_OFF    (CFG_OFF),
    .LED        (LED),
    .PHASE_DONE (PHASE_DONE)
`ifdef LED_DIM_EN
    ,
    .DUTY       (DUTY)
`endif
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  // mask bits: [2]=LED [1]=PHASE_DONE [0]=CFG_READY
  typedef struct {
    int       cyc;
    logic     led;
    logic     pd;
    logic     rdy;
    bit [2:0] mask;
    string    name;
  } exp_t;

  exp_t sbq[$];

  task automatic sb_push(input int dly, input logic led, input logic pd, input logic rdy,
                         input bit [2:0] mask, input string name);
    exp_t e;
    e.cyc  = cyc + dly;
    e.led  = led;
    e.pd   = pd;
    e.rdy  = rdy;
    e.mask = mask;
    e.name = name;
    sbq.push_back(e);
  endtask

  always @(negedge CLK100MHZ) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        checks++;
        if ((sbq[i].cyc != cyc) ||
            (sbq[i].mask[2] && (LED        !== sbq[i].led)) ||
            (sbq[i].mask[1] && (PHASE_DONE !== sbq[i].pd))  ||
            (sbq[i].mask[0] && (CFG_READY  !== sbq[i].rdy))) begin
          failures++;
          $display("FAIL %s cyc=%0d: got led=%b pd=%b rdy=%b, expected led=%b pd=%b rdy=%b (mask %b, due cyc %0d)",
                   sbq[i].name, cyc, LED, PHASE_DONE, CFG_READY,
                   sbq[i].led, sbq[i].pd, sbq[i].rdy, sbq[i].mask, sbq[i].cyc);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic load(input logic [7:0] on_len, input logic [7:0] off_len);
    CFG_ON    = on_len;
    CFG_OFF   = off_len;
    CFG_VALID = 1'b1;
    step();
    CFG_VALID = 1'b0;
  endtask

  // One TICK followed by three quiet clocks; the expected outputs after the
  // tick edge and the single-cycle nature of PHASE_DONE are both scored.
  task automatic do_tick(input logic led, input logic pd, input logic rdy,
                         input logic cv, input string nm);
    TICK      = 1'b1;
    CFG_VALID = cv;
    sb_push(1, led, pd, rdy, 3'b111, nm);
    step();
    TICK      = 1'b0;
    CFG_VALID = 1'b0;
    sb_push(1, led, 1'b0, rdy, 3'b111, {nm, "_hold"});
    step();
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    sb_push(0, 1'b0, 1'b0, 1'b1, 3'b111, "reset_state");
    RST = 1'b0;

    // 2/1 pattern: 1,1,0 per tick, PHASE_DONE with each OFF->ON
    CFG_ON = 8'd2; CFG_OFF = 8'd1; CFG_VALID = 1'b1;
    sb_push(1, 1'b0, 1'b0, 1'b1, 3'b111, "idle_load_ready");
    step();
    CFG_VALID = 1'b0;
    ENABLE    = 1'b1;
    sb_push(1, 1'b1, 1'b0, 1'b1, 3'b111, "enable_led_rise");
    step();
    do_tick(1, 0, 1, 0, "p21_t1");
    do_tick(0, 0, 1, 0, "p21_t2");
    do_tick(1, 1, 1, 0, "p21_t3");
    do_tick(1, 0, 1, 0, "p21_t4");
    do_tick(0, 0, 1, 0, "p21_t5");
    do_tick(1, 1, 1, 0, "p21_t6");

    // on=0/off=3: dark with PHASE_DONE every third tick
    ENABLE = 1'b0;
    step();
    load(8'd0, 8'd3);
    ENABLE = 1'b1;
    step();
    sb_push(0, 1'b0, 1'b0, 1'b1, 3'b111, "p03_start");
    do_tick(0, 0, 1, 0, "p03_t1");
    do_tick(0, 0, 1, 0, "p03_t2");
    do_tick(0, 1, 1, 0, "p03_t3");
    do_tick(0, 0, 1, 0, "p03_t4");
    do_tick(0, 0, 1, 0, "p03_t5");
    do_tick(0, 1, 1, 0, "p03_t6");

    // on=3/off=0: lit with PHASE_DONE every third tick
    ENABLE = 1'b0;
    step();
    load(8'd3, 8'd0);
    ENABLE = 1'b1;
    step();
    sb_push(0, 1'b1, 1'b0, 1'b1, 3'b111, "p30_start");
    do_tick(1, 0, 1, 0, "p30_t1");
    do_tick(1, 0, 1, 0, "p30_t2");
    do_tick(1, 1, 1, 0, "p30_t3");
    do_tick(1, 0, 1, 0, "p30_t4");
    do_tick(1, 0, 1, 0, "p30_t5");
    do_tick(1, 1, 1, 0, "p30_t6");

    // mid-ON reconfig 2/1 -> 1/1 applies exactly at the boundary
    ENABLE = 1'b0;
    step();
    load(8'd2, 8'd1);
    ENABLE = 1'b1;
    step();
    do_tick(1, 0, 1, 0, "rc_t1");
    CFG_ON = 8'd1; CFG_OFF = 8'd1; CFG_VALID = 1'b1;
    sb_push(1, 1'b1, 1'b0, 1'b0, 3'b111, "rc_pending");
    step();
    CFG_VALID = 1'b0;
    do_tick(0, 0, 0, 0, "rc_t2");
    do_tick(1, 1, 1, 0, "rc_t3_boundary");
    do_tick(0, 0, 1, 0, "rc_t4");
    do_tick(1, 1, 1, 0, "rc_t5");
    do_tick(0, 0, 1, 0, "rc_t6");

    // disable during ON, TICK ignored in IDLE, re-enable restarts full ON
    do_tick(1, 1, 1, 0, "dis_t7");
    ENABLE = 1'b0;
    sb_push(1, 1'b0, 1'b0, 1'b1, 3'b111, "dis_led_off");
    step();
    do_tick(0, 0, 1, 0, "idle_tick");
    load(8'd3, 8'd1);
    ENABLE = 1'b1;
    sb_push(1, 1'b1, 1'b0, 1'b1, 3'b111, "reen_led_on");
    step();
    do_tick(1, 0, 1, 0, "reen_t1");
    do_tick(1, 0, 1, 0, "reen_t2");
    do_tick(0, 0, 1, 0, "reen_t3");
    do_tick(1, 1, 1, 0, "reen_t4");
    do_tick(1, 0, 1, 0, "reen_t5");
    ENABLE = 1'b0;
    sb_push(1, 1'b0, 1'b0, 1'b1, 3'b111, "dis2_led_off");
    step();
    ENABLE = 1'b1;
    sb_push(1, 1'b1, 1'b0, 1'b1, 3'b111, "reen2_led_on");
    step();
    do_tick(1, 0, 1, 0, "restart_t1");
    do_tick(1, 0, 1, 0, "restart_t2");
    do_tick(0, 0, 1, 0, "restart_t3");

    // reset mid-pattern with a pending config, ENABLE held high
    CFG_ON = 8'd2; CFG_OFF = 8'd2; CFG_VALID = 1'b1;
    sb_push(1, 1'b0, 1'b0, 1'b0, 3'b111, "pend_before_rst");
    step();
    CFG_VALID = 1'b0;
    RST       = 1'b1;
    sb_push(1, 1'b0, 1'b0, 1'b1, 3'b111, "rst_cycle1");
    step();
    sb_push(1, 1'b0, 1'b0, 1'b1, 3'b111, "rst_cycle2");
    step();
    RST = 1'b0;
    do_tick(0, 0, 1, 0, "post_rst_t1");
    do_tick(0, 0, 1, 0, "post_rst_t2");
    sb_push(1, 1'b0, 1'b0, 1'b1, 3'b111, "post_rst_load");
    CFG_ON = 8'd2; CFG_OFF = 8'd1; CFG_VALID = 1'b1;
    step();
    CFG_VALID = 1'b0;
    sb_push(1, 1'b1, 1'b0, 1'b1, 3'b111, "post_rst_led_on");
    step();

    // config accepted on the boundary edge waits one more period
    do_tick(1, 0, 1, 0, "ba_t1");
    do_tick(0, 0, 1, 0, "ba_t2");
    CFG_ON = 8'd1; CFG_OFF = 8'd2;
    do_tick(1, 1, 0, 1, "ba_accept_boundary");
    do_tick(1, 0, 0, 0, "ba_old_t1");
    do_tick(0, 0, 0, 0, "ba_old_t2");
    do_tick(1, 1, 1, 0, "ba_apply");
    do_tick(0, 0, 1, 0, "ba_new_t1");
    do_tick(0, 0, 1, 0, "ba_new_t2");
    do_tick(1, 1, 1, 0, "ba_new_t3");

`ifdef LED_DIM_EN
    begin
      int lit;
      ENABLE = 1'b0;
      step();
      DUTY = 4'd4;
      load(8'd5, 8'd5);
      ENABLE = 1'b1;
      step();
      lit = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge CLK100MHZ);
        lit += int'(LED);
      end
      checks++;
      if (lit != 4) begin
        failures++;
        $display("FAIL dim_on_phase: lit %0d of 16 clocks, expected 4", lit);
      end
      for (int t = 0; t < 5; t++) begin
        TICK = 1'b1;
        step();
        TICK = 1'b0;
        step();
        step();
        step();
      end
      lit = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge CLK100MHZ);
        lit += int'(LED);
      end
      checks++;
      if (lit != 0) begin
        failures++;
        $display("FAIL dim_off_phase: lit %0d of 16 clocks, expected 0", lit);
      end
    end
`endif

    step();
    step();
    step();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left unchecked, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
